// File: rtl/tva_sa_pkg.sv
// Shared types and sizing helpers for the systolic tile controller.
package tva_sa_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, OUT} tile_state_e;

  function automatic int k_w(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Cycles for the last operand pair to reach PE(M-1,N-1) and settle.
  function automatic int drain_cycles(input int m, input int n, input int pipe_lat);
    return 1 + (m - 1) + (n - 1) + pipe_lat;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Per-lane delay line: lane l is delayed by l cycles, lane 0 is a straight wire.
module sa_skew_line #(
  parameter int W     = 16,
  parameter int LANES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic [LANES-1:0][W-1:0]   i_d,
  output logic [LANES-1:0][W-1:0]   o_d
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (l == 0) begin : g_wire
      assign o_d[0] = i_d[0];
    end else begin : g_dly
      logic [l-1:0][W-1:0] r_sr;
      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= i_d[l];
          for (int s = 1; s < l; s++) r_sr[s] <= r_sr[s-1];
        end
      end
      assign o_d[l] = r_sr[l-1];
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequences one M x N systolic tile: clear, feed K skewed operand vectors, drain,
// capture the psum bank and stream it out row by row with valid/ready.
module systolic_tile_ctrl
  import tva_sa_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int M        = 16,
  parameter int N        = 16,
  parameter int K_MAX    = 256,
  parameter int PIPE_LAT = 2,
  parameter int K_W      = k_w(K_MAX)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [K_W-1:0]                     k_len_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               act_rd_en_o,
  output logic [K_W-1:0]                     act_rd_addr_o,
  input  logic [M-1:0][DATA_W-1:0]           act_rd_data_i,
  output logic                               wgt_rd_en_o,
  output logic [K_W-1:0]                     wgt_rd_addr_o,
  input  logic [N-1:0][DATA_W-1:0]           wgt_rd_data_i,
  output logic                               sa_tile_start_o,
  output logic [M-1:0][DATA_W-1:0]           sa_act_o,
  output logic [N-1:0][DATA_W-1:0]           sa_wgt_o,
  input  logic [M-1:0][N-1:0][ACC_W-1:0]     sa_psum_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [$clog2(M)-1:0]               res_row_o,
  output logic [N-1:0][ACC_W-1:0]            res_data_o
);

  localparam int ROW_W   = $clog2(M);
  localparam int DRAIN_N = drain_cycles(M, N, PIPE_LAT);
  localparam int DC_W    = $clog2(DRAIN_N + 1);
  localparam logic [K_W-1:0] KMAX_V = K_W'(K_MAX);

  tile_state_e                    r_state;
  logic [K_W-1:0]                 r_klen, r_kcnt;
  logic [DC_W-1:0]                r_dcnt;
  logic [ROW_W-1:0]               r_row;
  logic                           r_busy, r_done, r_tile_start, r_rd_en, r_rd_vld, r_res_valid;
  logic [M-1:0][N-1:0][ACC_W-1:0] r_cap;

  logic [K_W-1:0]                 w_klen;
  logic [M-1:0][DATA_W-1:0]       w_act;
  logic [N-1:0][DATA_W-1:0]       w_wgt;

  assign w_klen = (k_len_i > KMAX_V) ? KMAX_V : k_len_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_klen       <= '0;
      r_kcnt       <= '0;
      r_dcnt       <= '0;
      r_row        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tile_start <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_cap        <= '0;
    end else begin
      r_done       <= 1'b0;
      r_tile_start <= 1'b0;
      r_rd_vld     <= r_rd_en;
      case (r_state)
        IDLE: begin
          // r_done blocks a start presented in the done cycle itself
          if (start_i && !r_done) begin
            r_klen       <= w_klen;
            r_kcnt       <= '0;
            r_busy       <= 1'b1;
            r_tile_start <= 1'b1;
            r_state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_klen == '0) begin
            r_state <= CAPTURE;
          end else begin
            r_rd_en <= 1'b1;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (r_kcnt == r_klen - 1'b1) begin
            r_rd_en <= 1'b0;
            r_kcnt  <= '0;
            r_dcnt  <= DC_W'(DRAIN_N - 1);
            r_state <= DRAIN;
          end else begin
            r_kcnt <= r_kcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (r_dcnt == '0) r_state <= CAPTURE;
          else              r_dcnt  <= r_dcnt - 1'b1;
        end
        CAPTURE: begin
          r_cap       <= (r_klen == '0) ? '0 : sa_psum_i;
          r_row       <= '0;
          r_res_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (res_ready_i) begin
            if (r_row == ROW_W'(M - 1)) begin
              r_res_valid <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lanes see zero unless a read issued last cycle returned data.
  assign w_act = r_rd_vld ? act_rd_data_i : '0;
  assign w_wgt = r_rd_vld ? wgt_rd_data_i : '0;

  sa_skew_line #(.W(DATA_W), .LANES(M)) u_act_skew (
    .clk(clk), .rst(rst), .i_clr(r_tile_start), .i_d(w_act), .o_d(sa_act_o));

  sa_skew_line #(.W(DATA_W), .LANES(N)) u_wgt_skew (
    .clk(clk), .rst(rst), .i_clr(r_tile_start), .i_d(w_wgt), .o_d(sa_wgt_o));

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign act_rd_en_o     = r_rd_en;
  assign wgt_rd_en_o     = r_rd_en;
  assign act_rd_addr_o   = r_kcnt;
  assign wgt_rd_addr_o   = r_kcnt;
  assign sa_tile_start_o = r_tile_start;
  assign res_valid_o     = r_res_valid;
  assign res_row_o       = r_row;
  assign res_data_o      = r_cap[r_row];

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed + randomized bench for systolic_tile_ctrl with an operand SRAM model
// and a behavioural output-stationary array model driving sa_psum_i.
module tb_systolic_tile_ctrl;
  localparam int DW = 16, AW = 32, M = 4, N = 4, KMAX = 8, PL = 2;
  localparam int KW = $clog2(KMAX + 1);
  localparam int D  = 1 + (M - 1) + (N - 1) + PL;

  logic                        clk = 1'b0, rst, start_i, res_ready_i;
  logic [KW-1:0]               k_len_i;
  logic                        busy_o, done_o, act_rd_en_o, wgt_rd_en_o, sa_tile_start_o, res_valid_o;
  logic [KW-1:0]               act_rd_addr_o, wgt_rd_addr_o;
  logic [M-1:0][DW-1:0]        act_rd_data_i, sa_act_o;
  logic [N-1:0][DW-1:0]        wgt_rd_data_i, sa_wgt_o;
  logic [M-1:0][N-1:0][AW-1:0] sa_psum_i;
  logic [$clog2(M)-1:0]        res_row_o;
  logic [N-1:0][AW-1:0]        res_data_o;

  int vectors = 0, miscompares = 0;
  logic [DW-1:0] amem [KMAX][M];
  logic [DW-1:0] wmem [KMAX][N];
  logic [AW-1:0] expr [M][N];
  logic [AW-1:0] psum [M][N];
  logic [DW-1:0] ah [M][N];
  logic [DW-1:0] wh [N][M];

  systolic_tile_ctrl #(.DATA_W(DW), .ACC_W(AW), .M(M), .N(N), .K_MAX(KMAX), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i), .busy_o(busy_o), .done_o(done_o),
    .act_rd_en_o(act_rd_en_o), .act_rd_addr_o(act_rd_addr_o), .act_rd_data_i(act_rd_data_i),
    .wgt_rd_en_o(wgt_rd_en_o), .wgt_rd_addr_o(wgt_rd_addr_o), .wgt_rd_data_i(wgt_rd_data_i),
    .sa_tile_start_o(sa_tile_start_o), .sa_act_o(sa_act_o), .sa_wgt_o(sa_wgt_o),
    .sa_psum_i(sa_psum_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_row_o(res_row_o), .res_data_o(res_data_o));

  always #5 clk = ~clk;

  // Operand SRAMs: 1-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    for (int i = 0; i < M; i++)
      if (act_rd_en_o && act_rd_addr_o < KW'(KMAX)) act_rd_data_i[i] <= amem[act_rd_addr_o][i];
      else act_rd_data_i[i] <= DW'($urandom);
    for (int j = 0; j < N; j++)
      if (wgt_rd_en_o && wgt_rd_addr_o < KW'(KMAX)) wgt_rd_data_i[j] <= wmem[wgt_rd_addr_o][j];
      else wgt_rd_data_i[j] <= DW'($urandom);
  end

  // Array: PE(i,j) multiplies act lane i seen j cycles ago with wgt lane j seen i cycles ago.
  always @(negedge clk) begin
    logic signed [AW-1:0] p;
    if (rst === 1'b1 || sa_tile_start_o) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
        psum[i][j] = '0; ah[i][j] = '0; wh[j][i] = '0;
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        for (int d = N - 1; d > 0; d--) ah[i][d] = ah[i][d-1];
        ah[i][0] = sa_act_o[i];
      end
      for (int j = 0; j < N; j++) begin
        for (int d = M - 1; d > 0; d--) wh[j][d] = wh[j][d-1];
        wh[j][0] = sa_wgt_o[j];
      end
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
        p = $signed(ah[i][j]) * $signed(wh[j][i]);
        psum[i][j] = psum[i][j] + p;
      end
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) sa_psum_i[i][j] = psum[i][j];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_done"}, 64'(done_o), 0);
    chk({tag, "_rden"}, 64'({act_rd_en_o, wgt_rd_en_o}), 0);
    chk({tag, "_addr"}, 64'({act_rd_addr_o, wgt_rd_addr_o}), 0);
    chk({tag, "_tstart"}, 64'(sa_tile_start_o), 0);
    chk({tag, "_sa_ops"}, 64'({sa_act_o, sa_wgt_o}), 0);
    chk({tag, "_res"}, 64'({res_valid_o, res_row_o}), 0);
    chk({tag, "_resdata"}, 64'(|res_data_o), 0);
  endtask

  task automatic fill(input bit pattern);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < M; i++) amem[k][i] = pattern ? DW'(i == k) : DW'($urandom);
      for (int j = 0; j < N; j++) wmem[k][j] = pattern ? DW'(j + 1 + 4 * k) : DW'($urandom);
    end
  endtask

  // Runs one tile from a posedge+1 point; checks reads, skew, timing, rows, done.
  task automatic run_tile(input int klen, input int stall_row, input int stall_len,
                          input bit rnd_ready, input int poke_d);
    int K, d, hs, stalls, first_out;
    bit fin;
    logic signed [AW-1:0] p;
    logic [AW-1:0] acc;
    logic [DW-1:0] e;
    K = (klen > KMAX) ? KMAX : klen;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      acc = '0;
      for (int k = 0; k < K; k++) begin
        p = $signed(amem[k][i]) * $signed(wmem[k][j]);
        acc = acc + p;
      end
      expr[i][j] = acc;
    end
    first_out = (K == 0) ? 1 : K + D + 1;
    start_i = 1'b1; k_len_i = KW'(klen);
    @(posedge clk); #1; start_i = 1'b0;
    chk("clear_busy", 64'(busy_o), 1);
    chk("clear_tstart", 64'(sa_tile_start_o), 1);
    chk("clear_rden", 64'(act_rd_en_o), 0);
    d = -1; hs = 0; stalls = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge clk); #1; d++;
      start_i = (d == poke_d);
      if (d <= K + M + 1) begin
        chk("rd_en", 64'({act_rd_en_o, wgt_rd_en_o}), (K > 0 && d < K) ? 64'd3 : 64'd0);
        if (K > 0 && d < K) chk("rd_addr", 64'({act_rd_addr_o, wgt_rd_addr_o}), 64'({KW'(d), KW'(d)}));
        for (int i = 0; i < M; i++) begin
          e = (d - 1 - i >= 0 && d - 1 - i < K) ? amem[d-1-i][i] : '0;
          chk($sformatf("skew_act%0d_d%0d", i, d), 64'(sa_act_o[i]), 64'(e));
        end
        for (int j = 0; j < N; j++) begin
          e = (d - 1 - j >= 0 && d - 1 - j < K) ? wmem[d-1-j][j] : '0;
          chk($sformatf("skew_wgt%0d_d%0d", j, d), 64'(sa_wgt_o[j]), 64'(e));
        end
      end
      if (d == first_out - 1) chk("pre_out_valid", 64'(res_valid_o), 0);
      if (d == first_out) chk("first_out_valid", 64'(res_valid_o), 1);
      if (done_o) begin
        chk("done_rows", 64'(hs), 64'(M));
        chk("done_busy", 64'(busy_o), 0);
        chk("done_valid", 64'(res_valid_o), 0);
        start_i = 1'b1;
        fin = 1'b1;
      end else if (res_valid_o) begin
        chk("res_busy", 64'(busy_o), 1);
        chk("res_row", 64'(res_row_o), 64'(hs));
        for (int j = 0; j < N; j++)
          chk($sformatf("res_r%0d_c%0d", hs, j), 64'(res_data_o[j]), 64'(expr[hs][j]));
        if (hs == stall_row && stalls < stall_len) begin
          res_ready_i = 1'b0; stalls++;
        end else begin
          res_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (res_ready_i) hs++;
      end
    end
    if (!fin) chk("tile_timeout", 0, 1);
    @(posedge clk); #1; start_i = 1'b0; res_ready_i = 1'b0;
    chk("post_done_pulse", 64'(done_o), 0);
    chk("post_done_ignored", 64'({busy_o, sa_tile_start_o}), 0);
    @(posedge clk); #1;
    chk("post_done_idle", 64'({busy_o, sa_tile_start_o, act_rd_en_o}), 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b1; k_len_i = KW'(3); res_ready_i = 1'b0;
    fill(1'b0);
    repeat (3) begin @(posedge clk); #1; check_zero("reset"); end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1; check_zero("after_reset");

    fill(1'b1); run_tile(4, -1, 0, 1'b0, -100);      // identity activations
    fill(1'b0); run_tile(3, -1, 0, 1'b0, -100);      // skew window
    fill(1'b0); run_tile(4, 1, 5, 1'b0, -100);       // backpressure at row 1
    fill(1'b0); run_tile(0, 2, 3, 1'b0, 1);          // k_len=0 plus start while busy
    fill(1'b0); run_tile(13, -1, 0, 1'b1, -100);     // clamps to K_MAX
    fill(1'b0); run_tile(KMAX, -1, 0, 1'b1, 5);
    repeat (4) begin
      fill(1'b0); run_tile($urandom_range(1, KMAX), $urandom_range(0, M - 1), $urandom_range(0, 4), 1'b1, -100);
    end

    // Reset in DRAIN aborts the tile without done_o.
    fill(1'b0);
    start_i = 1'b1; k_len_i = KW'(3);
    @(posedge clk); #1; start_i = 1'b0;
    repeat (3 + 3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_zero("abort");
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 64'({done_o, busy_o, res_valid_o}), 0);
    end
    fill(1'b0); run_tile(2, -1, 0, 1'b1, -100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
